hxmpp_event_sequencer: RTL and testbench
========================================

Name: hxmpp_event_sequencer

Overview:
Per-event scheduler that sits in front of one hxmpp instance and owns its write/read/clear ports. It accepts a hit stream (SSID + hit info) and a readout-request stream over valid/ready handshakes. It enforces the event phases WRITE -> DRAIN -> READ -> CLEAR, so writes and reads never overlap and the HNM/HCM/HIM pipeline settles before readout. It then clears the memory for the next event.

Parameters:
ROWINDEXBITS_HCM, 7, SSID/row index width for writeSSID/readSSID.
HITINFOBITS, 16, hit info width.
WRITE_GAP, 1, minimum cycles between hx_write pulses (1 = back-to-back).
DRAIN_CYCLES, 8, idle cycles after last write before the first read (HNM->HCM->HIM latency).
CLEAR_CYCLES, 2, cycles hx_clear is held between events.
READ_TIMEOUT, 255, max cycles waiting for hx_readFinished per read.
CNTBITS, 16, width of hit_count.

Ports:
clk  in  1  clock, all logic rising-edge.
reset  in  1  asynchronous, active-low (0 = reset).
hit_valid  in  1  hit beat valid.
hit_ready  out  1  hit beat accepted when valid&ready.
hit_ssid  in  ROWINDEXBITS_HCM  hit SSID.
hit_info  in  HITINFOBITS  hit info.
hit_last  in  1  final hit of event.
rd_valid  in  1  readout request valid.
rd_ready  out  1  request accepted when valid&ready.
rd_ssid  in  ROWINDEXBITS_HCM  SSID to read.
rd_last  in  1  final request of event.
hx_write  out  1  one-cycle write strobe to hxmpp.
hx_writeSSID  out  ROWINDEXBITS_HCM  registered SSID.
hx_writeHitInfo  out  HITINFOBITS  registered hit info.
hx_read  out  1  one-cycle read strobe.
hx_readSSID  out  ROWINDEXBITS_HCM  registered read SSID.
hx_readFinished  in  1  hxmpp read completion.
hx_clear  out  1  active-high clear to hxmpp reset.
event_done  out  1  one-cycle pulse at end of CLEAR.
busy  out  1  state != IDLE.
hit_count  out  CNTBITS  writes issued this event, saturating.
err_timeout  out  1  sticky read-timeout flag.

Behaviour:
- All outputs registered. Reset values: state=CLEAR, hx_clear=1, all other outputs 0, counters 0. On reset deassertion the FSM runs a full CLEAR (CLEAR_CYCLES) and then enters IDLE. event_done does not pulse for this power-up clear.
- Reset asserted mid-operation aborts any phase immediately. In-flight hits and reads are dropped.
- IDLE: hit_ready=1. If hit_valid is accepted: issue a write, go to WRITE, or to DRAIN if hit_last. Else if rd_valid: go to READ without accepting the request that cycle (empty-write event). Hit has priority when both are valid.
- Write issue: on acceptance, hx_write=1 next cycle with SSID/info captured. hit_count increments, saturating at all-ones.
- WRITE: hit_ready=1 only when the gap counter permits (>=WRITE_GAP cycles since the last hx_write). hit_last on an accepted beat -> DRAIN. rd_ready=0.
- DRAIN: counter loads DRAIN_CYCLES when entered. hit_ready=rd_ready=0. Goes to READ when the counter reaches 0.
- READ: rd_ready=1. On acceptance: hx_read=1 next cycle with SSID captured, latch rd_last, go to READ_WAIT.
- READ_WAIT: rd_ready=0. Wait for hx_readFinished or for READ_TIMEOUT cycles to elapse. A timeout sets err_timeout (sticky until reset) and is treated as finished. On finish: go to CLEAR if rd_last was latched, else back to READ.
- hx_readFinished outside READ_WAIT is ignored.
- CLEAR: hx_clear=1 for exactly CLEAR_CYCLES. On the last cycle, event_done=1 and hit_count resets to 0 (reset-exit clear excepted). Then go to IDLE.
- hx_write and hx_read are never high in the same cycle. At most one read is outstanding.
- Data inputs are sampled only on handshake cycles. Held values are don't-care otherwise.

Test Plan:
- Reset release -> hx_clear=1 for 2 cycles, then IDLE; no event_done; hit_ready=1.
- 3 back-to-back hits (SSID 5,9,5; last on third) -> 3 consecutive hx_write pulses, hit_count=3, 8 DRAIN cycles with both ready signals low, then rd_ready=1.
- WRITE_GAP=3 with hit_valid held high -> hx_write pulses exactly 3 cycles apart.
- 2 reads (SSID 5, then 9 with rd_last); hxmpp answers readFinished after 4 cycles each -> hx_read twice, rd_ready low while waiting. Then hx_clear for 2 cycles, one event_done, hit_count=0.
- hx_readFinished never arrives -> err_timeout=1 after 255 cycles, FSM returns to READ, flag persists until reset.
- Reset asserted in READ_WAIT -> outputs at reset values asynchronously, hx_clear=1; after release, CLEAR then IDLE.

Source files
------------

// File: rtl/hxmpp_event_sequencer.sv
// Event scheduler in front of one hxmpp: sequences WRITE -> DRAIN -> READ -> CLEAR
// so writes and reads never overlap and the HNM/HCM/HIM pipeline settles before readout.
module hxmpp_event_sequencer #(
   parameter int ROWINDEXBITS_HCM = 7,
   parameter int HITINFOBITS      = 16,
   parameter int WRITE_GAP        = 1,
   parameter int DRAIN_CYCLES     = 8,
   parameter int CLEAR_CYCLES     = 2,
   parameter int READ_TIMEOUT     = 255,
   parameter int CNTBITS          = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        hit_valid,
   output logic                        hit_ready,
   input  logic [ROWINDEXBITS_HCM-1:0] hit_ssid,
   input  logic [HITINFOBITS-1:0]      hit_info,
   input  logic                        hit_last,
   input  logic                        rd_valid,
   output logic                        rd_ready,
   input  logic [ROWINDEXBITS_HCM-1:0] rd_ssid,
   input  logic                        rd_last,
   output logic                        hx_write,
   output logic [ROWINDEXBITS_HCM-1:0] hx_writeSSID,
   output logic [HITINFOBITS-1:0]      hx_writeHitInfo,
   output logic                        hx_read,
   output logic [ROWINDEXBITS_HCM-1:0] hx_readSSID,
   input  logic                        hx_readFinished,
   output logic                        hx_clear,
   output logic                        event_done,
   output logic                        busy,
   output logic [CNTBITS-1:0]          hit_count,
   output logic                        err_timeout
);

   localparam int GW = (WRITE_GAP    < 2) ? 1 : $clog2(WRITE_GAP + 1);
   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam int CW = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES + 1);
   localparam int TW = (READ_TIMEOUT < 2) ? 1 : $clog2(READ_TIMEOUT + 1);
   localparam logic [GW-1:0] GAP_LOAD = (WRITE_GAP > 1) ? GW'(WRITE_GAP - 1) : '0;
   localparam logic [TW-1:0] TO_LAST  = (READ_TIMEOUT > 0) ? TW'(READ_TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_DRAIN, S_READ, S_READ_WAIT, S_CLEAR
   } state_t;

   state_t        state, state_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [DW-1:0] drn_cnt, drn_n;
   logic [CW-1:0] clr_cnt, clr_n;
   logic [TW-1:0] to_cnt, to_n;
   logic          last_q, last_n;
   logic          pwr_q, pwr_n;
   logic          hit_acc, rd_acc, tmo, ev_n;

   assign hit_acc = hit_valid & hit_ready;
   assign rd_acc  = rd_valid & rd_ready;

   always_comb begin
      state_n = state;
      gap_n   = gap_cnt;
      drn_n   = drn_cnt;
      clr_n   = clr_cnt;
      to_n    = to_cnt;
      last_n  = last_q;
      tmo     = 1'b0;

      // gap counts down the cycles that must pass before the next hit may be taken
      if (hit_acc)
         gap_n = GAP_LOAD;
      else if (gap_cnt != '0)
         gap_n = gap_cnt - 1'b1;

      case (state)
         S_IDLE: begin
            if (hit_acc) begin
               if (hit_last) begin
                  state_n = S_DRAIN;
                  drn_n   = DW'(DRAIN_CYCLES);
               end else begin
                  state_n = S_WRITE;
               end
            end else if (rd_valid) begin
               state_n = S_READ;
            end
         end
         S_WRITE: begin
            if (hit_acc && hit_last) begin
               state_n = S_DRAIN;
               drn_n   = DW'(DRAIN_CYCLES);
            end
         end
         S_DRAIN: begin
            // counter holds the DRAIN cycles remaining including this one
            if (drn_cnt <= DW'(1))
               state_n = S_READ;
            else
               drn_n = drn_cnt - 1'b1;
         end
         S_READ: begin
            if (rd_acc) begin
               state_n = S_READ_WAIT;
               last_n  = rd_last;
               to_n    = '0;
            end
         end
         S_READ_WAIT: begin
            if (hx_readFinished || to_cnt == TO_LAST) begin
               tmo = ~hx_readFinished;
               if (last_q) begin
                  state_n = S_CLEAR;
                  clr_n   = CW'(CLEAR_CYCLES);
               end else begin
                  state_n = S_READ;
               end
            end else begin
               to_n = to_cnt + 1'b1;
            end
         end
         S_CLEAR: begin
            if (clr_cnt <= CW'(1))
               state_n = S_IDLE;
            else
               clr_n = clr_cnt - 1'b1;
         end
         default: state_n = S_CLEAR;
      endcase

      // power-up clear is flagged so it produces no event_done
      pwr_n = pwr_q & ~(state == S_CLEAR && state_n == S_IDLE);
      ev_n  = (state_n == S_CLEAR) && (clr_n <= CW'(1)) && !pwr_n;
   end

   // outputs are registered from next-state values so they line up with the state they describe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_CLEAR;
         gap_cnt         <= '0;
         drn_cnt         <= '0;
         clr_cnt         <= CW'(CLEAR_CYCLES);
         to_cnt          <= '0;
         last_q          <= 1'b0;
         pwr_q           <= 1'b1;
         hit_ready       <= 1'b0;
         rd_ready        <= 1'b0;
         hx_write        <= 1'b0;
         hx_writeSSID    <= '0;
         hx_writeHitInfo <= '0;
         hx_read         <= 1'b0;
         hx_readSSID     <= '0;
         hx_clear        <= 1'b1;
         event_done      <= 1'b0;
         busy            <= 1'b0;
         hit_count       <= '0;
         err_timeout     <= 1'b0;
      end else begin
         state      <= state_n;
         gap_cnt    <= gap_n;
         drn_cnt    <= drn_n;
         clr_cnt    <= clr_n;
         to_cnt     <= to_n;
         last_q     <= last_n;
         pwr_q      <= pwr_n;
         hit_ready  <= (state_n == S_IDLE) || (state_n == S_WRITE && gap_n == '0);
         rd_ready   <= (state_n == S_READ);
         hx_write   <= hit_acc;
         hx_read    <= rd_acc;
         hx_clear   <= (state_n == S_CLEAR);
         event_done <= ev_n;
         busy       <= (state_n != S_IDLE);
         err_timeout <= err_timeout | tmo;
         if (hit_acc) begin
            hx_writeSSID    <= hit_ssid;
            hx_writeHitInfo <= hit_info;
         end
         if (rd_acc)
            hx_readSSID <= rd_ssid;
         if (ev_n)
            hit_count <= '0;
         else if (hit_acc && hit_count != '1)
            hit_count <= hit_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hxmpp_event_sequencer.sv
// Directed bench for hxmpp_event_sequencer: reset clear, write burst, drain, reads,
// timeout, async reset mid-read, and write gap spacing on a WRITE_GAP=3 instance.
module tb_hxmpp_event_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        hit_valid, hit_last, rd_valid, rd_last, hx_readFinished;
   logic [6:0]  hit_ssid, rd_ssid;
   logic [15:0] hit_info;
   logic        hit_ready, rd_ready, hx_write, hx_read, hx_clear, event_done, busy, err_timeout;
   logic [6:0]  hx_writeSSID, hx_readSSID;
   logic [15:0] hx_writeHitInfo, hit_count;

   logic        h3_valid, h3_last, h3_ready, rr3, w3, r3, c3, d3, b3, e3;
   logic [6:0]  w3_ssid, r3_ssid;
   logic [15:0] w3_info, cnt3;

   int n_chk = 0, n_err = 0, cyc = 0, ev_cnt = 0, overlap = 0;

   always #5 clk = ~clk;

   hxmpp_event_sequencer dut (
      .clk(clk), .reset(reset),
      .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ssid(hit_ssid),
      .hit_info(hit_info), .hit_last(hit_last),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ssid(rd_ssid), .rd_last(rd_last),
      .hx_write(hx_write), .hx_writeSSID(hx_writeSSID), .hx_writeHitInfo(hx_writeHitInfo),
      .hx_read(hx_read), .hx_readSSID(hx_readSSID), .hx_readFinished(hx_readFinished),
      .hx_clear(hx_clear), .event_done(event_done), .busy(busy),
      .hit_count(hit_count), .err_timeout(err_timeout)
   );

   hxmpp_event_sequencer #(.WRITE_GAP(3)) dut3 (
      .clk(clk), .reset(reset),
      .hit_valid(h3_valid), .hit_ready(h3_ready), .hit_ssid(hit_ssid),
      .hit_info(hit_info), .hit_last(h3_last),
      .rd_valid(1'b0), .rd_ready(rr3), .rd_ssid(rd_ssid), .rd_last(1'b0),
      .hx_write(w3), .hx_writeSSID(w3_ssid), .hx_writeHitInfo(w3_info),
      .hx_read(r3), .hx_readSSID(r3_ssid), .hx_readFinished(hx_readFinished),
      .hx_clear(c3), .event_done(d3), .busy(b3),
      .hit_count(cnt3), .err_timeout(e3)
   );

   always @(posedge clk) begin
      if (event_done) ev_cnt++;
      if (hx_write && hx_read) overlap++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int n, last_w, nw;
      logic bad;
      reset = 1'b0; hit_valid = 0; hit_last = 0; rd_valid = 0; rd_last = 0;
      hx_readFinished = 0; hit_ssid = '0; hit_info = '0; rd_ssid = '0;
      h3_valid = 0; h3_last = 0;
      step(); step();
      check("rst_clear", hx_clear, 1);
      check("rst_ready", hit_ready, 0);
      check("rst_busy", busy, 0);

      // power-up clear
      reset = 1'b1;
      step();
      check("pu_clear1", hx_clear, 1);
      step();
      check("pu_clear_off", hx_clear, 0);
      check("pu_idle_ready", hit_ready, 1);
      check("pu_no_done", ev_cnt, 0);

      // three back-to-back hits, last on third
      hit_valid = 1; hit_ssid = 7'd5; hit_info = 16'h1111;
      step();
      check("w1", hx_write, 1);
      check("w1_ssid", hx_writeSSID, 5);
      check("w1_info", hx_writeHitInfo, 16'h1111);
      hit_ssid = 7'd9; hit_info = 16'h2222;
      step();
      check("w2_ssid", {hx_write, hx_writeSSID}, {1'b1, 7'd9});
      hit_ssid = 7'd5; hit_info = 16'h3333; hit_last = 1;
      step();
      check("w3_ssid", {hx_write, hx_writeSSID}, {1'b1, 7'd5});
      check("w3_info", hx_writeHitInfo, 16'h3333);
      check("hit_count3", hit_count, 3);
      hit_valid = 0; hit_last = 0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         bad |= hit_ready | rd_ready;
         if (i > 0) bad |= hx_write;
         step();
      end
      check("drain_quiet", bad, 0);
      check("drain_done_rd_ready", rd_ready, 1);

      // two reads, completion 4 cycles after each hx_read
      rd_valid = 1; rd_ssid = 7'd5; rd_last = 0;
      step();
      check("rd1", {hx_read, hx_readSSID}, {1'b1, 7'd5});
      check("rd1_wait_ready", rd_ready, 0);
      rd_valid = 0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin step(); bad |= rd_ready | hx_read; end
      check("rd1_waiting", bad, 0);
      hx_readFinished = 1;
      step();
      hx_readFinished = 0;
      check("rd1_back_ready", rd_ready, 1);
      rd_valid = 1; rd_ssid = 7'd9; rd_last = 1;
      step();
      check("rd2", {hx_read, hx_readSSID}, {1'b1, 7'd9});
      rd_valid = 0; rd_last = 0;
      for (int i = 0; i < 3; i++) step();
      hx_readFinished = 1;
      step();
      hx_readFinished = 0;
      check("clr1", {hx_clear, event_done}, 2'b10);
      step();
      check("clr2", {hx_clear, event_done}, 2'b11);
      check("clr_count0", hit_count, 0);
      step();
      check("post_idle", {hx_clear, hit_ready, busy}, 3'b010);
      check("one_done", ev_cnt, 1);
      check("no_err", err_timeout, 0);

      // stray completion in IDLE is ignored
      hx_readFinished = 1;
      step();
      hx_readFinished = 0;
      check("stray_fin", {busy, hit_ready}, 2'b01);

      // empty-write event: request in IDLE is not accepted, then timeout
      rd_valid = 1; rd_ssid = 7'd3; rd_last = 0;
      step();
      check("idle_rd_noaccept", {hx_read, rd_ready}, 2'b01);
      step();
      check("to_rd", {hx_read, hx_readSSID}, {1'b1, 7'd3});
      rd_valid = 0;
      n = 0;
      while (!err_timeout && n < 400) begin step(); n++; end
      check("timeout_cycles", n, 255);
      check("timeout_back_read", rd_ready, 1);
      for (int i = 0; i < 5; i++) step();
      check("err_sticky", err_timeout, 1);

      // async reset while waiting for a read
      rd_valid = 1; rd_last = 1;
      step();
      rd_valid = 0; rd_last = 0;
      step();
      check("pre_rst_wait", {rd_ready, busy}, 2'b01);
      #2 reset = 1'b0;
      #1;
      check("async_rst", {hx_clear, err_timeout, busy, rd_ready}, 4'b1000);
      step();
      reset = 1'b1;
      step();
      check("rst2_clear", hx_clear, 1);
      step();
      check("rst2_idle", {hx_clear, hit_ready}, 2'b01);
      check("rst2_no_done", ev_cnt, 1);

      // WRITE_GAP=3 instance with valid held high
      h3_valid = 1; last_w = -1; nw = 0; bad = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (w3) begin
            if (last_w >= 0 && i - last_w != 3) bad = 1;
            last_w = i; nw++;
         end
      end
      h3_valid = 0;
      check("gap3_spacing", bad, 0);
      check("gap3_writes", nw, 4);
      check("gap3_count", cnt3, 4);
      check("no_overlap", overlap, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
